// File: rtl/netwalk_port_arbiter_pkg.sv
// Shared types and default parameters for the netwalk port arbiter.
package netwalk_port_arbiter_pkg;

  localparam int unsigned NW_ARB_IDX_WIDTH_DEF  = 4;
  localparam int unsigned NW_ARB_MAX_HOLD_DEF   = 64;
  localparam int unsigned NW_ARB_HOLD_WIDTH_DEF = 7;

  // Arbiter FSM states
  typedef enum logic {
    NW_ARB_IDLE  = 1'b0,
    NW_ARB_GRANT = 1'b1
  } nw_arb_state_e;

endpackage : netwalk_port_arbiter_pkg

// File: rtl/netwalk_rr_pick.sv
// Rotating-priority picker: first set request at or after rr_ptr, wrapping upward.
module netwalk_rr_pick
  import netwalk_port_arbiter_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = NW_ARB_IDX_WIDTH_DEF
) (
  input  logic [(1<<IDX_WIDTH)-1:0] req,
  input  logic [IDX_WIDTH-1:0]      rr_ptr,
  output logic [IDX_WIDTH-1:0]      pick_idx,
  output logic                      pick_any
);

  localparam int unsigned NUM_REQ = 1 << IDX_WIDTH;

  logic [IDX_WIDTH-1:0] idx;

  // Scan from rr_ptr upward; index arithmetic wraps naturally at IDX_WIDTH bits
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = rr_ptr + IDX_WIDTH'(i);
      if (!pick_any && req[idx]) begin
        pick_any = 1'b1;
        pick_idx = idx;
      end
    end
  end

endmodule : netwalk_rr_pick

// File: rtl/netwalk_port_arbiter.sv
// Round-robin port arbiter with hold budget and a forced idle cycle between grants.
module netwalk_port_arbiter
  import netwalk_port_arbiter_pkg::*;
#(
  parameter int unsigned ARB_IDX_WIDTH  = NW_ARB_IDX_WIDTH_DEF,
  parameter int unsigned MAX_HOLD       = NW_ARB_MAX_HOLD_DEF,
  parameter int unsigned HOLD_CNT_WIDTH = NW_ARB_HOLD_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [(1<<ARB_IDX_WIDTH)-1:0] req,
  input  logic                          grant_done,
  output logic [ARB_IDX_WIDTH-1:0]      grant_idx,
  output logic                          grant_valid,
  output logic                          timeout_pulse
);

  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_SAT  = '1;
  localparam bit                        HOLD_EN   = (MAX_HOLD != 0);

  // Hold counter must be able to reach MAX_HOLD-1 without wrapping
  if ((2 ** HOLD_CNT_WIDTH) <= MAX_HOLD) begin : g_hold_width_check
    $error("netwalk_port_arbiter: HOLD_CNT_WIDTH too small for MAX_HOLD");
  end

  nw_arb_state_e               state;
  logic [ARB_IDX_WIDTH-1:0]    rr_ptr;
  logic [HOLD_CNT_WIDTH-1:0]   hold_cnt;
  logic [ARB_IDX_WIDTH-1:0]    pick_idx;
  logic                        pick_any;
  logic                        owner_req_c;
  logic                        budget_out_c;
  logic                        release_c;

  netwalk_rr_pick #(
    .IDX_WIDTH (ARB_IDX_WIDTH)
  ) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Exit causes: owner done, owner dropped its request, or hold budget exhausted
  always_comb begin
    owner_req_c  = req[grant_idx];
    budget_out_c = HOLD_EN && (hold_cnt == HOLD_LAST);
    release_c    = grant_done || !owner_req_c || budget_out_c;
  end

  // Arbiter FSM with registered outputs, hold counter and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= NW_ARB_IDLE;
      grant_idx     <= '0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
    end else begin
      case (state)
        NW_ARB_IDLE: begin
          timeout_pulse <= 1'b0;
          if (pick_any) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= NW_ARB_GRANT;
          end
        end
        NW_ARB_GRANT: begin
          if (release_c) begin
            grant_valid   <= 1'b0;
            rr_ptr        <= grant_idx + ARB_IDX_WIDTH'(1);
            hold_cnt      <= '0;
            // Pulse only when the budget is the sole reason for leaving
            timeout_pulse <= budget_out_c && !grant_done && owner_req_c;
            state         <= NW_ARB_IDLE;
          end else begin
            timeout_pulse <= 1'b0;
            if (HOLD_EN && (hold_cnt != HOLD_SAT)) begin
              hold_cnt <= hold_cnt + HOLD_CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state       <= NW_ARB_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : netwalk_port_arbiter

// File: tb/tb_netwalk_port_arbiter.sv
// Bench for netwalk_port_arbiter: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_netwalk_port_arbiter;

  localparam int unsigned W    = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned MAXH = 4;
  localparam int unsigned HCW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          grant_done;
  logic [N-1:0]  req;
  logic [W-1:0]  grant_idx;
  logic          grant_valid;
  logic          timeout_pulse;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: who owns the port, for how many cycles, and where the search resumes
  bit mv;
  bit mt;
  int mi;
  int mp;
  int mh;

  bit prev_v;
  int prev_i;

  netwalk_port_arbiter #(
    .ARB_IDX_WIDTH  (W),
    .MAX_HOLD       (MAXH),
    .HOLD_CNT_WIDTH (HCW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant_done    (grant_done),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv = 1'b0; mt = 1'b0; mi = 0; mp = 0; mh = 0;
    prev_v = 1'b0; prev_i = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge
  task automatic model_edge();
    bit fin, drop, out, found;
    if (!reset) return;
    if (mv) begin
      fin  = grant_done;
      drop = !req[mi];
      out  = (MAXH != 0) && (mh == MAXH);
      if (fin || drop || out) begin
        mv = 1'b0;
        mp = (mi + 1) % N;
        mt = out && !fin && !drop;
        mh = 0;
      end else begin
        mh = mh + 1;
        mt = 1'b0;
      end
    end else begin
      mt = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(mp + k) % N]) begin
          found = 1'b1;
          mv = 1'b1;
          mi = (mp + k) % N;
          mh = 1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("grant_valid", 32'(grant_valid), 32'(mv));
    check("timeout_pulse", 32'(timeout_pulse), 32'(mt));
    if (mv) check("grant_idx", 32'(grant_idx), 32'(mi));
    if (prev_v && grant_valid) check("no_switch_without_gap", 32'(grant_idx), 32'(prev_i));
    prev_v = grant_valid;
    prev_i = int'(grant_idx);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_grant(output int idx);
    int budget;
    budget = 40;
    idx = -1;
    while (!grant_valid && budget > 0) begin
      step();
      budget--;
    end
    if (grant_valid) idx = int'(grant_idx);
    else check("wait_grant_timeout", 32'(grant_valid), 32'd1);
  endtask

  initial begin
    int g;
    int hi;
    int exp_seq [4];
    exp_seq = '{0, 2, 7, 0};

    reset      = 1'b0;
    req        = 16'hFFFF;
    grant_done = 1'b0;
    model_reset();

    // 1. Reset held with every port requesting
    #1;
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("t1_valid", 32'(grant_valid), 32'd1);
    check("t1_idx", 32'(grant_idx), 32'd0);

    // 2. Round robin over ports 0, 2, 7
    apply_reset();
    req = 16'h0085;
    for (int s = 0; s < 4; s++) begin
      wait_grant(g);
      check("t2_seq", 32'(g), 32'(exp_seq[s]));
      step();
      grant_done = 1'b1;
      step();
      grant_done = 1'b0;
      check("t2_gap", 32'(grant_valid), 32'd0);
    end

    // 3. Pointer wrap from 15 back to 0
    apply_reset();
    req = 16'h4000;
    wait_grant(g);
    check("t3_first", 32'(g), 32'd14);
    grant_done = 1'b1;
    step();
    grant_done = 1'b0;
    req = 16'h8001;
    wait_grant(g);
    check("t3_wrap15", 32'(g), 32'd15);
    grant_done = 1'b1;
    step();
    grant_done = 1'b0;
    wait_grant(g);
    check("t3_wrap0", 32'(g), 32'd0);

    // 4. Hold budget expiry on a lone requester
    apply_reset();
    req = 16'h0010;
    wait_grant(g);
    check("t4_idx", 32'(g), 32'd4);
    hi = 1;
    while (grant_valid && hi < 20) begin
      step();
      if (grant_valid) hi++;
    end
    check("t4_high_cycles", 32'(hi), 32'(MAXH));
    check("t4_pulse_on_fall", 32'(timeout_pulse), 32'd1);
    wait_grant(g);
    check("t4_regrant", 32'(g), 32'd4);
    check("t4_pulse_cleared", 32'(timeout_pulse), 32'd0);

    // 5a. Done coincident with the last budget cycle is a normal exit
    apply_reset();
    req = 16'h0010;
    wait_grant(g);
    repeat (3) step();
    grant_done = 1'b1;
    step();
    grant_done = 1'b0;
    check("t5_valid", 32'(grant_valid), 32'd0);
    check("t5_no_pulse", 32'(timeout_pulse), 32'd0);

    // 5b. Owner drops its request mid-grant
    wait_grant(g);
    step();
    req = 16'h0000;
    step();
    check("t5_drop_valid", 32'(grant_valid), 32'd0);
    check("t5_drop_pulse", 32'(timeout_pulse), 32'd0);

    // 6. Asynchronous reset mid-grant, then restart from port 0
    req = 16'h0010;
    wait_grant(g);
    step();
    step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid", 32'(grant_valid), 32'd0);
    check("t6_async_pulse", 32'(timeout_pulse), 32'd0);
    step();
    reset = 1'b1;
    req = 16'h0011;
    wait_grant(g);
    check("t6_restart", 32'(g), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      grant_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        check("rand_async_valid", 32'(grant_valid), 32'd0);
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_netwalk_port_arbiter
